// File: rtl/i2c_sht_target.sv
// i2c_sht_target: I2C target that emulates a temperature/humidity sensor.
// A write transfer delivers one command byte (Cmd_Out / Cmd_Valid). A read
// transfer returns a 6-byte frame: TempMSB, TempLSB, TempCRC, HumMSB,
// HumLSB, HumCRC. SCL/SDA are asynchronous and are synchronized before
// any decoding takes place.
//
// Build option: define SHT_TARGET_CRC_EN to compute real CRC-8 bytes
// (polynomial 0x31, init 0xFF). Leave it undefined and both CRC bytes
// read back as 8'hFF, with no CRC logic built.
module i2c_sht_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h44,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Scl_In,
   input  logic        Sda_In,
   output logic        Sda_Drive_Low,
   input  logic [15:0] Temp_Data,
   input  logic [15:0] Hum_Data,
   input  logic        Data_Ready,
   output logic [7:0]  Cmd_Out,
   output logic        Cmd_Valid,
   output logic [2:0]  Target_State_Out
);

   localparam logic [2:0] T_IDLE     = 3'b000;
   localparam logic [2:0] T_ADDR     = 3'b001;
   localparam logic [2:0] T_ADDR_ACK = 3'b010;
   localparam logic [2:0] T_CMD      = 3'b011;
   localparam logic [2:0] T_CMD_ACK  = 3'b100;
   localparam logic [2:0] T_TX       = 3'b101;
   localparam logic [2:0] T_TX_ACK   = 3'b110;
   localparam logic [2:0] T_WAIT     = 3'b111;

`ifdef SHT_TARGET_CRC_EN
   // CRC-8 over a 16-bit word, MSB first, poly 0x31, init 0xFF,
   // no reflection and no final XOR.
   function automatic logic [7:0] crc8_word(input logic [15:0] w);
      logic [7:0] c;
      c = 8'hFF;
      for (int i = 15; i >= 0; i--) begin
         if (c[7] ^ w[i])
            c = {c[6:0], 1'b0} ^ 8'h31;
         else
            c = {c[6:0], 1'b0};
      end
      return c;
   endfunction

   function automatic logic [7:0] crc_byte(input logic [15:0] w);
      return crc8_word(w);
   endfunction
`else
   // Without the CRC option the checksum bytes read as all ones.
   function automatic logic [7:0] crc_byte(input logic [15:0] w);
      logic unused_w;
      unused_w = ^w;
      return 8'hFF | {7'b0, unused_w & 1'b0};
   endfunction
`endif

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_d;
   logic                   sda_d;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_rise;
   logic                   scl_fall;
   logic                   start_det;
   logic                   stop_det;

   logic [2:0]             state;
   logic [2:0]             bit_cnt;
   logic [2:0]             byte_idx;
   logic [6:0]             shift_reg;
   logic                   rw_bit;
   logic                   cmd_upd;
   logic [7:0]             frame [6];
   logic [7:0]             rx_byte;
   logic [7:0]             tx_cur;

   // Synchronizer chains for both bus lines plus one delay flop each for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync[0] <= Scl_In;
         sda_sync[0] <= Sda_In;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            scl_sync[i] <= scl_sync[i-1];
            sda_sync[i] <= sda_sync[i-1];
         end
         scl_d <= scl_s;
         sda_d <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   // Bus conditions: SDA moving while SCL is high
   assign start_det = sda_d & ~sda_s & scl_s;
   assign stop_det  = ~sda_d & sda_s & scl_s;

   // Byte being assembled: previous seven bits plus the bit on the line now
   assign rx_byte   = {shift_reg, sda_s};
   assign tx_cur    = frame[byte_idx];

   assign Target_State_Out = state;

   // Protocol FSM: samples on SCL rise, changes SDA drive only on SCL fall
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= T_IDLE;
         bit_cnt       <= 3'd0;
         byte_idx      <= 3'd0;
         shift_reg     <= 7'd0;
         rw_bit        <= 1'b0;
         cmd_upd       <= 1'b0;
         Cmd_Out       <= 8'h00;
         Cmd_Valid     <= 1'b0;
         Sda_Drive_Low <= 1'b0;
         for (int i = 0; i < 6; i++)
            frame[i] <= 8'h00;
      end else begin
         cmd_upd   <= 1'b0;
         Cmd_Valid <= cmd_upd;
         if (start_det) begin
            // START or repeated START restarts address reception from any state
            state         <= T_ADDR;
            bit_cnt       <= 3'd0;
            Sda_Drive_Low <= 1'b0;
         end else if (stop_det) begin
            state         <= T_IDLE;
            Sda_Drive_Low <= 1'b0;
         end else begin
            case (state)
               T_IDLE: begin
                  Sda_Drive_Low <= 1'b0;
               end
               T_ADDR: begin
                  if (scl_rise) begin
                     shift_reg <= rx_byte[6:0];
                     bit_cnt   <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        rw_bit <= sda_s;
                        // Reads are only acknowledged once data is available
                        if (rx_byte[7:1] == TARGET_ADDR && (!sda_s || Data_Ready))
                           state <= T_ADDR_ACK;
                        else
                           state <= T_WAIT;
                     end
                  end
               end
               T_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!Sda_Drive_Low) begin
                        Sda_Drive_Low <= 1'b1;
                     end else if (rw_bit) begin
                        // Snapshot the measurement so the frame cannot tear mid-read
                        frame[0]      <= Temp_Data[15:8];
                        frame[1]      <= Temp_Data[7:0];
                        frame[2]      <= crc_byte(Temp_Data);
                        frame[3]      <= Hum_Data[15:8];
                        frame[4]      <= Hum_Data[7:0];
                        frame[5]      <= crc_byte(Hum_Data);
                        byte_idx      <= 3'd0;
                        bit_cnt       <= 3'd0;
                        Sda_Drive_Low <= ~Temp_Data[15];
                        state         <= T_TX;
                     end else begin
                        Sda_Drive_Low <= 1'b0;
                        bit_cnt       <= 3'd0;
                        state         <= T_CMD;
                     end
                  end
               end
               T_CMD: begin
                  if (scl_rise) begin
                     shift_reg <= rx_byte[6:0];
                     bit_cnt   <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        Cmd_Out <= rx_byte;
                        cmd_upd <= 1'b1;
                        state   <= T_CMD_ACK;
                     end
                  end
               end
               T_CMD_ACK: begin
                  if (scl_fall) begin
                     if (!Sda_Drive_Low) begin
                        Sda_Drive_Low <= 1'b1;
                     end else begin
                        Sda_Drive_Low <= 1'b0;
                        state         <= T_WAIT;
                     end
                  end
               end
               T_TX: begin
                  // bit_cnt counts bits already clocked out; the MSB went out on entry
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7)
                        state <= T_TX_ACK;
                  end else if (scl_fall) begin
                     Sda_Drive_Low <= ~tx_cur[3'd7 - bit_cnt];
                  end
               end
               T_TX_ACK: begin
                  if (scl_fall) begin
                     Sda_Drive_Low <= 1'b0;
                  end else if (scl_rise) begin
                     // Master ACK with bytes left continues; NACK or end of frame stops
                     if (!sda_s && byte_idx < 3'd5) begin
                        byte_idx <= byte_idx + 3'd1;
                        bit_cnt  <= 3'd0;
                        state    <= T_TX;
                     end else begin
                        state <= T_WAIT;
                     end
                  end
               end
               T_WAIT: begin
                  Sda_Drive_Low <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
